// File: rtl/aud_rec_capture.sv
// rtl/aud_rec_capture.sv - WM8731 ADC I2S left-channel capture into auto-incrementing SRAM writes
module aud_rec_capture #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_aud_bclk,
    input  logic              i_aud_adclrck,
    input  logic              i_aud_adcdat,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_last_addr,
    output logic              o_full,
    output logic [1:0]        o_state
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REC   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t            state_q;
    logic              bclk_s1_q, bclk_s2_q, bclk_s3_q;
    logic              lrck_s1_q, lrck_s2_q, lrck_prev_q;
    logic              dat_s1_q, dat_s2_q;
    logic              armed_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [ADDR_W-1:0] cnt_q, addr_q, last_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q, full_q;

    logic              bclk_rise;
    logic              frame_start;
    logic              last_bit;
    logic [ADDR_W-1:0] cnt_done;

    assign bclk_rise   = bclk_s2_q & ~bclk_s3_q;
    // The I2S delay slot: first BCLK rise after LRCK went low
    assign frame_start = bclk_rise & ~lrck_s2_q & lrck_prev_q;
    assign last_bit    = bclk_rise & armed_q & (bit_cnt_q == CNT_W'(DATA_W - 1));
    // Counter value once a write in flight (o_wr_en high) is accounted for
    assign cnt_done    = cnt_q + ADDR_W'(wr_q);

    // Synchronise raw codec signals and track LRCK at the previous BCLK rise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bclk_s1_q   <= 1'b0;
            bclk_s2_q   <= 1'b0;
            bclk_s3_q   <= 1'b0;
            lrck_s1_q   <= 1'b0;
            lrck_s2_q   <= 1'b0;
            lrck_prev_q <= 1'b0;
            dat_s1_q    <= 1'b0;
            dat_s2_q    <= 1'b0;
        end else begin
            bclk_s1_q <= i_aud_bclk;
            bclk_s2_q <= bclk_s1_q;
            bclk_s3_q <= bclk_s2_q;
            lrck_s1_q <= i_aud_adclrck;
            lrck_s2_q <= lrck_s1_q;
            dat_s1_q  <= i_aud_adcdat;
            dat_s2_q  <= dat_s1_q;
            if (bclk_rise) begin
                lrck_prev_q <= lrck_s2_q;
            end
        end
    end

    // Record control FSM, sample deserialiser and registered write port
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            last_q    <= '0;
            wr_q      <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    armed_q <= 1'b0;
                    if (i_start && !i_pause && !i_stop) begin
                        state_q <= S_REC;
                        cnt_q   <= '0;
                        full_q  <= 1'b0;
                    end
                end
                S_REC: begin
                    cnt_q <= cnt_done;
                    if (wr_q && (cnt_q == MAX_ADDR)) begin
                        // Last address written: recording ends on its own
                        state_q <= S_IDLE;
                        full_q  <= 1'b1;
                        last_q  <= cnt_done;
                        armed_q <= 1'b0;
                    end else if (i_stop) begin
                        state_q <= S_IDLE;
                        last_q  <= cnt_done;
                        armed_q <= 1'b0;
                    end else if (i_pause) begin
                        state_q <= S_PAUSE;
                        armed_q <= 1'b0;
                    end else if (frame_start) begin
                        armed_q   <= 1'b1;
                        bit_cnt_q <= '0;
                    end else if (bclk_rise && armed_q) begin
                        shift_q   <= {shift_q[DATA_W-2:0], dat_s2_q};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            armed_q <= 1'b0;
                            wr_q    <= 1'b1;
                            addr_q  <= cnt_q;
                            data_q  <= {shift_q[DATA_W-2:0], dat_s2_q};
                        end
                    end
                end
                S_PAUSE: begin
                    armed_q <= 1'b0;
                    cnt_q   <= cnt_done;
                    if (i_stop) begin
                        state_q <= S_IDLE;
                        last_q  <= cnt_done;
                    end else if (i_start && !i_pause) begin
                        state_q <= S_REC;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    armed_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_en     = wr_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;
    assign o_last_addr = last_q;
    assign o_full      = full_q;
    assign o_state     = state_q;
endmodule

// File: tb/tb_aud_rec_capture.sv
// tb/tb_aud_rec_capture.sv - scoreboard bench for aud_rec_capture with an I2S frame-level model
`timescale 1ns/1ps
module tb_aud_rec_capture;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic bclk = 1'b0, lrck = 1'b1, dat = 1'b0;

    logic        wr_en [2];
    logic [19:0] addr  [2];
    logic [15:0] data  [2];
    logic [19:0] last  [2];
    logic        full  [2];
    logic [1:0]  st    [2];

    always #41.667 clk = ~clk;

    aud_rec_capture u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_aud_bclk(bclk), .i_aud_adclrck(lrck), .i_aud_adcdat(dat),
        .o_wr_en(wr_en[0]), .o_addr(addr[0]), .o_data(data[0]),
        .o_last_addr(last[0]), .o_full(full[0]), .o_state(st[0])
    );

    aud_rec_capture #(.MAX_ADDR(20'h00003)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_aud_bclk(bclk), .i_aud_adclrck(lrck), .i_aud_adcdat(dat),
        .o_wr_en(wr_en[1]), .o_addr(addr[1]), .o_data(data[1]),
        .o_last_addr(last[1]), .o_full(full[1]), .o_state(st[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: recorder state per DUT, evaluated frame by frame
    localparam int IDLE = 0, REC = 1, PAUSE = 2;
    logic [19:0] max_v [2] = '{20'hFFFFF, 20'h00003};
    int          m_st  [2];
    logic [19:0] m_cnt [2];
    logic [19:0] m_last[2];
    logic        m_full[2];
    bit          cap   [2];
    logic [35:0] exp_q [2][$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = IDLE; m_cnt[d] = '0; m_last[d] = '0; m_full[d] = 1'b0; cap[d] = 1'b0;
        end
    endfunction

    // c = {stop, pause, start}; stop beats pause beats start
    function automatic void m_cmd(input logic [2:0] c);
        for (int d = 0; d < 2; d++) begin
            if (m_st[d] == IDLE) begin
                if (c == 3'b001) begin
                    m_st[d] = REC; m_cnt[d] = '0; m_full[d] = 1'b0;
                end
            end else if (c[2]) begin
                m_st[d] = IDLE; m_last[d] = m_cnt[d]; cap[d] = 1'b0;
            end else if (m_st[d] == REC && c[1]) begin
                m_st[d] = PAUSE; cap[d] = 1'b0;
            end else if (m_st[d] == PAUSE && c[0] && !c[1]) begin
                m_st[d] = REC;
            end
        end
    endfunction

    function automatic void m_sample(input logic [15:0] left);
        for (int d = 0; d < 2; d++) begin
            if (cap[d]) begin
                exp_q[d].push_back({m_cnt[d], left});
                if (m_cnt[d] == max_v[d]) begin
                    m_st[d] = IDLE; m_full[d] = 1'b1; m_last[d] = m_cnt[d] + 20'd1;
                end
                m_cnt[d] = m_cnt[d] + 20'd1;
                cap[d] = 1'b0;
            end
        end
    endfunction

    task automatic pulse(input logic [2:0] c);
        @(negedge clk);
        {stop, pause, start} = c;
        @(negedge clk);
        {stop, pause, start} = 3'b000;
        m_cmd(c);
    endtask

    task automatic reset_check();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_wr_en%0d", d), 32'(wr_en[d]), 0);
            chk($sformatf("rst_addr%0d", d), 32'(addr[d]), 0);
            chk($sformatf("rst_data%0d", d), 32'(data[d]), 0);
            chk($sformatf("rst_last%0d", d), 32'(last[d]), 0);
            chk($sformatf("rst_full%0d", d), 32'(full[d]), 0);
            chk($sformatf("rst_state%0d", d), 32'(st[d]), 0);
        end
    endtask

    task automatic check_status();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("state%0d", d), 32'(st[d]), 32'(m_st[d]));
            chk($sformatf("full%0d", d), 32'(full[d]), 32'(m_full[d]));
            chk($sformatf("last_addr%0d", d), 32'(last[d]), 32'(m_last[d]));
        end
    endtask

    task automatic idle_slots(input int n);
        for (int i = 0; i < n; i++) begin
            bclk = 1'b0; lrck = 1'b1; dat = 1'($urandom);
            #333; bclk = 1'b1; #333;
        end
    endtask

    // One I2S frame of 40 BCLKs: 20 with LRCK low (delay, 16 left bits, 3 pad), then right
    task automatic frame(input logic [15:0] left, input int cmd_slot, input logic [2:0] cmd, input bit rst9);
        logic [15:0] right;
        right = 16'($urandom);
        for (int s = 0; s < 40; s++) begin
            bclk = 1'b0;
            lrck = (s >= 20);
            if (s >= 1 && s <= 16)       dat = left[16 - s];
            else if (s >= 21 && s <= 36) dat = right[36 - s];
            else                         dat = 1'($urandom);
            if (s == cmd_slot) pulse(cmd);
            if (rst9 && s == 9) reset_check();
            #333;
            bclk = 1'b1;
            if (s == 0) for (int d = 0; d < 2; d++) cap[d] = (m_st[d] == REC);
            if (s == 16) m_sample(left);
            #333;
        end
        check_status();
    endtask

    // Monitor: every write strobe is matched against the expected queue
    logic        prev_wr [2] = '{1'b0, 1'b0};
    logic [35:0] mon_e;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wr_en[d]) begin
                chk($sformatf("wr_single_cycle%0d", d), 32'(prev_wr[d]), 0);
                if (exp_q[d].size() == 0) begin
                    chk($sformatf("unexpected_write%0d addr=%0h", d, addr[d]), 1, 0);
                end else begin
                    mon_e = exp_q[d].pop_front();
                    chk($sformatf("wr_addr%0d", d), 32'(addr[d]), 32'(mon_e[35:16]));
                    chk($sformatf("wr_data%0d", d), 32'(data[d]), 32'(mon_e[15:0]));
                end
            end
            prev_wr[d] = wr_en[d];
        end
    end

    initial begin
        logic [2:0] rc;
        int         rs;
        m_reset();
        reset_check();
        idle_slots(4);
        frame(16'($urandom), -1, 3'b000, 0);

        // Three known samples at addresses 0..2
        frame(16'($urandom), 30, 3'b001, 0);
        frame(16'h8001, -1, 3'b000, 0);
        frame(16'h7FFE, -1, 3'b000, 0);
        frame(16'h1234, 30, 3'b100, 0);

        // Start mid left word, 5 samples, pause 3 frames, resume 2 samples, stop
        frame(16'($urandom), 6, 3'b001, 0);
        for (int i = 0; i < 4; i++) frame(16'($urandom), -1, 3'b000, 0);
        frame(16'($urandom), 30, 3'b010, 0);
        frame(16'($urandom), -1, 3'b000, 0);
        frame(16'($urandom), -1, 3'b000, 0);
        frame(16'($urandom), 30, 3'b001, 0);
        frame(16'($urandom), -1, 3'b000, 0);
        frame(16'($urandom), 30, 3'b100, 0);

        // Simultaneous stop+pause+start in REC
        frame(16'($urandom), 30, 3'b001, 0);
        frame(16'($urandom), 30, 3'b111, 0);

        // pause+start in PAUSE stays paused; stop in IDLE leaves last address
        frame(16'($urandom), 30, 3'b001, 0);
        frame(16'($urandom), 30, 3'b010, 0);
        frame(16'($urandom), 30, 3'b011, 0);
        frame(16'($urandom), 30, 3'b100, 0);
        frame(16'($urandom), 30, 3'b100, 0);

        // Reset between bits 8 and 9 of a sample
        frame(16'($urandom), 30, 3'b001, 0);
        frame(16'($urandom), -1, 3'b000, 1);
        frame(16'($urandom), 30, 3'b001, 0);

        // Randomised samples and commands
        for (int i = 0; i < 16; i++) begin
            rs = $urandom_range(2, 39);
            if (rs == 16 || rs == 17) rs = 25;
            rc = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 1) == 0) rs = -1;
            frame(16'($urandom), rs, rc, 0);
        end

        idle_slots(4);
        for (int d = 0; d < 2; d++) chk($sformatf("pending_writes%0d", d), 32'(exp_q[d].size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
